// File: rtl/block_sequencer.sv
// ============================================================================
// block_sequencer: runs the conv/pool stages of one VGG block in order, with a
// block start/busy/done handshake, per-stage watchdog, abort and cycle counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module block_sequencer #(
  parameter int NUM_STAGES      = 4,
  parameter int STAGE_IDX_WIDTH = 2,
  parameter int TIMEOUT_CYCLES  = 1048576,
  parameter int TIMER_WIDTH     = 21,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [NUM_STAGES-1:0]      i_stage_done,
  output logic [NUM_STAGES-1:0]      o_stage_start,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error,
  output logic [STAGE_IDX_WIDTH-1:0] o_stage_idx,
  output logic [CNT_WIDTH-1:0]       o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_FINISH = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [STAGE_IDX_WIDTH-1:0] c_LAST_STAGE = STAGE_IDX_WIDTH'(NUM_STAGES - 1);
  localparam logic [TIMER_WIDTH-1:0]     c_TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam bit                         c_WDOG_EN    = (TIMEOUT_CYCLES != 0);

  state_t                     r_state, w_state_nxt;
  logic [STAGE_IDX_WIDTH-1:0] r_stage_idx, w_stage_idx_nxt;
  logic [TIMER_WIDTH-1:0]     r_timer, w_timer_nxt;
  logic [CNT_WIDTH-1:0]       r_cycle_count, w_cycle_count_nxt;

  logic [NUM_STAGES-1:0]      w_stage_sel;
  logic                       w_cur_done;
  logic                       w_busy;

  // One-hot of the current stage; masks foreign done bits and drives the start pulse.
  assign w_stage_sel = NUM_STAGES'(1) << r_stage_idx;
  assign w_cur_done  = |(i_stage_done & w_stage_sel);
  assign w_busy      = (r_state == S_LAUNCH) || (r_state == S_WAIT) || (r_state == S_FINISH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_stage_idx   <= '0;
      r_timer       <= '0;
      r_cycle_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_stage_idx   <= w_stage_idx_nxt;
      r_timer       <= w_timer_nxt;
      r_cycle_count <= w_cycle_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_stage_idx_nxt   = r_stage_idx;
    w_timer_nxt       = r_timer;
    w_cycle_count_nxt = r_cycle_count;

    if (w_busy && (r_cycle_count != '1)) begin
      w_cycle_count_nxt = r_cycle_count + CNT_WIDTH'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt       = S_LAUNCH;
          w_stage_idx_nxt   = '0;
          w_timer_nxt       = '0;
          w_cycle_count_nxt = '0;
        end
      end
      S_LAUNCH: begin
        w_timer_nxt = '0;
        w_state_nxt = i_abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        // Completion outranks the watchdog when both land on the same cycle.
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_cur_done) begin
          if (r_stage_idx == c_LAST_STAGE) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_stage_idx_nxt = r_stage_idx + STAGE_IDX_WIDTH'(1);
            w_state_nxt     = S_LAUNCH;
          end
        end else if (c_WDOG_EN && (r_timer == c_TIMER_LAST)) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_timer_nxt = r_timer + TIMER_WIDTH'(1);
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      S_ERROR: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_stage_start = (r_state == S_LAUNCH) ? w_stage_sel : '0;
  assign o_busy        = w_busy;
  assign o_done        = (r_state == S_FINISH);
  assign o_error       = (r_state == S_ERROR);
  assign o_stage_idx   = r_stage_idx;
  assign o_cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_block_sequencer.sv
// ============================================================================
// tb_block_sequencer: directed scoreboard bench for block_sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_block_sequencer;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_abort;
  logic [3:0]  resp_done;
  logic [3:0]  spur_done;
  logic [3:0]  stage_done;
  logic [3:0]  o_stage_start;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [1:0]  o_stage_idx;
  logic [31:0] o_cycle_count;

  // Second instance: single stage, watchdog disabled.
  logic        s2_start;
  logic        s2_abort;
  logic        s2_done;
  logic [0:0]  s2_stage_start;
  logic        s2_busy;
  logic        s2_o_done;
  logic        s2_error;
  logic [0:0]  s2_stage_idx;
  logic [31:0] s2_cycle_count;

  assign stage_done = resp_done | spur_done;

  block_sequencer #(
    .NUM_STAGES(4), .STAGE_IDX_WIDTH(2), .TIMEOUT_CYCLES(16), .TIMER_WIDTH(5), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_stage_done(stage_done), .o_stage_start(o_stage_start), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error), .o_stage_idx(o_stage_idx),
    .o_cycle_count(o_cycle_count)
  );

  block_sequencer #(
    .NUM_STAGES(1), .STAGE_IDX_WIDTH(1), .TIMEOUT_CYCLES(0), .TIMER_WIDTH(21), .CNT_WIDTH(32)
  ) dut_nowd (
    .clk(clk), .rst_n(rst_n), .i_start(s2_start), .i_abort(s2_abort),
    .i_stage_done(s2_done), .o_stage_start(s2_stage_start), .o_busy(s2_busy),
    .o_done(s2_o_done), .o_error(s2_error), .o_stage_idx(s2_stage_idx),
    .o_cycle_count(s2_cycle_count)
  );

  typedef struct {
    int         cyc;
    logic [3:0] start;
    logic       done;
  } ev_t;

  ev_t sbq[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_fail = 0;
  int  delay[4];
  int  pend[4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_at(input int c);
    go(c);
    @(negedge clk);
  endtask

  task automatic push(input int c, input logic [3:0] s, input logic d);
    ev_t e;
    e.cyc   = c;
    e.start = s;
    e.done  = d;
    sbq.push_back(e);
  endtask

  // A full run with every stage answering 5 cycles after its start.
  task automatic push_run(input int t);
    push(t + 1,  4'b0001, 1'b0);
    push(t + 7,  4'b0010, 1'b0);
    push(t + 13, 4'b0100, 1'b0);
    push(t + 19, 4'b1000, 1'b0);
    push(t + 25, 4'b0000, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start"}, 64'(o_stage_start), 64'd0);
    check({tag, "_busy"},  64'(o_busy),        64'd0);
    check({tag, "_done"},  64'(o_done),        64'd0);
    check({tag, "_error"}, 64'(o_error),       64'd0);
    check({tag, "_idx"},   64'(o_stage_idx),   64'd0);
    check({tag, "_count"}, 64'(o_cycle_count), 64'd0);
  endtask

  task automatic run_nominal(input string tag, input bit inject);
    int t;
    t = cyc;
    push_run(t);
    i_start = 1'b1;
    go(t + 1);
    i_start = 1'b0;
    @(negedge clk);
    check({tag, "_busy_c1"}, 64'(o_busy), 64'd1);
    check({tag, "_idx_c1"},  64'(o_stage_idx), 64'd0);
    go(t + 9);
    if (inject) spur_done = 4'b1000;
    go(t + 10);
    spur_done = 4'b0000;
    if (inject) i_start = 1'b1;
    go(t + 11);
    i_start = 1'b0;
    chk_at(t + 15);
    check({tag, "_idx_c15"},  64'(o_stage_idx), 64'd2);
    chk_at(t + 25);
    check({tag, "_busy_c25"}, 64'(o_busy), 64'd1);
    check({tag, "_cnt_c25"},  64'(o_cycle_count), 64'd24);
    chk_at(t + 26);
    check({tag, "_busy_end"}, 64'(o_busy), 64'd0);
    check({tag, "_err_end"},  64'(o_error), 64'd0);
    check({tag, "_cnt_end"},  64'(o_cycle_count), 64'd25);
    check({tag, "_idx_end"},  64'(o_stage_idx), 64'd3);
    check({tag, "_sb_empty"}, 64'(sbq.size()), 64'd0);
  endtask

  // Stage responder: answers a start on bit k with done delay[k] cycles later (0 = never).
  initial begin
    resp_done = 4'b0000;
    for (int k = 0; k < 4; k++) pend[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (pend[k] > 0) begin
          pend[k]      = pend[k] - 1;
          resp_done[k] = (pend[k] == 0);
        end else begin
          resp_done[k] = 1'b0;
        end
        if (o_stage_start[k] && (delay[k] > 0)) pend[k] = delay[k];
      end
    end
  end

  // Scoreboard consumer: every start pulse or done pulse must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if ((o_stage_start != 4'b0000) || o_done) begin
        if (sbq.size() == 0) begin
          check("unexpected_event", 64'({o_stage_start, o_done}), 64'd0);
        end else begin
          ev_t e;
          e = sbq.pop_front();
          check("ev_cycle", 64'(cyc), 64'(e.cyc));
          check("ev_start", 64'(o_stage_start), 64'(e.start));
          check("ev_done",  64'(o_done), 64'(e.done));
        end
      end
    end
  end

  initial begin
    int t;
    int u;
    rst_n     = 1'b0;
    i_start   = 1'b0;
    i_abort   = 1'b0;
    spur_done = 4'b0000;
    s2_start  = 1'b0;
    s2_abort  = 1'b0;
    s2_done   = 1'b0;
    for (int k = 0; k < 4; k++) delay[k] = 5;

    chk_at(2);
    check_reset_vals("reset");
    go(3);
    rst_n = 1'b1;
    go(5);

    run_nominal("nominal", 1'b0);

    // Watchdog: stage 2 never answers.
    go(cyc + 2);
    t = cyc;
    delay[2] = 0;
    push(t + 1,  4'b0001, 1'b0);
    push(t + 7,  4'b0010, 1'b0);
    push(t + 13, 4'b0100, 1'b0);
    i_start = 1'b1;
    go(t + 1);
    i_start = 1'b0;
    chk_at(t + 29);
    check("to_err_before", 64'(o_error), 64'd0);
    check("to_busy_before", 64'(o_busy), 64'd1);
    chk_at(t + 30);
    check("to_err", 64'(o_error), 64'd1);
    check("to_busy", 64'(o_busy), 64'd0);
    check("to_idx", 64'(o_stage_idx), 64'd2);
    check("to_cnt", 64'(o_cycle_count), 64'd29);
    go(t + 31);
    i_start = 1'b1;
    go(t + 32);
    i_start = 1'b0;
    chk_at(t + 35);
    check("to_err_hold", 64'(o_error), 64'd1);
    check("to_cnt_frozen", 64'(o_cycle_count), 64'd29);
    check("to_sb_empty", 64'(sbq.size()), 64'd0);
    go(t + 36);
    i_abort = 1'b1;
    go(t + 37);
    i_abort = 1'b0;
    @(negedge clk);
    check("to_abort_err", 64'(o_error), 64'd0);
    check("to_abort_busy", 64'(o_busy), 64'd0);
    delay[2] = 5;
    go(t + 39);
    run_nominal("after_err", 1'b0);

    // Done lands on the last allowed WAIT cycle of stage 1.
    go(cyc + 2);
    t = cyc;
    delay[1] = 16;
    push(t + 1,  4'b0001, 1'b0);
    push(t + 7,  4'b0010, 1'b0);
    push(t + 24, 4'b0100, 1'b0);
    push(t + 30, 4'b1000, 1'b0);
    push(t + 36, 4'b0000, 1'b1);
    i_start = 1'b1;
    go(t + 1);
    i_start = 1'b0;
    chk_at(t + 23);
    check("col_err_c23", 64'(o_error), 64'd0);
    check("col_idx_c23", 64'(o_stage_idx), 64'd1);
    chk_at(t + 24);
    check("col_err_c24", 64'(o_error), 64'd0);
    check("col_idx_c24", 64'(o_stage_idx), 64'd2);
    chk_at(t + 37);
    check("col_cnt", 64'(o_cycle_count), 64'd36);
    check("col_err_end", 64'(o_error), 64'd0);
    check("col_sb_empty", 64'(sbq.size()), 64'd0);
    delay[1] = 5;

    // Watchdog disabled: a 1000-cycle wait must not error.
    go(cyc + 2);
    u = cyc;
    s2_start = 1'b1;
    go(u + 1);
    s2_start = 1'b0;
    @(negedge clk);
    check("nowd_start", 64'(s2_stage_start), 64'd1);
    chk_at(u + 1001);
    check("nowd_err", 64'(s2_error), 64'd0);
    check("nowd_busy", 64'(s2_busy), 64'd1);
    s2_done = 1'b1;
    go(u + 1002);
    s2_done = 1'b0;
    @(negedge clk);
    check("nowd_done", 64'(s2_o_done), 64'd1);
    chk_at(u + 1003);
    check("nowd_busy_end", 64'(s2_busy), 64'd0);
    check("nowd_cnt", 64'(s2_cycle_count), 64'd1002);

    // Spurious done on stage 3 and a start while busy.
    go(cyc + 2);
    run_nominal("spurious", 1'b1);

    // Abort during stage 1 WAIT.
    go(cyc + 2);
    t = cyc;
    push(t + 1, 4'b0001, 1'b0);
    push(t + 7, 4'b0010, 1'b0);
    i_start = 1'b1;
    go(t + 1);
    i_start = 1'b0;
    go(t + 10);
    i_abort = 1'b1;
    go(t + 11);
    i_abort = 1'b0;
    @(negedge clk);
    check("ab_busy", 64'(o_busy), 64'd0);
    check("ab_idx", 64'(o_stage_idx), 64'd1);
    check("ab_cnt", 64'(o_cycle_count), 64'd10);
    chk_at(t + 40);
    check("ab_busy_late", 64'(o_busy), 64'd0);
    check("ab_sb_empty", 64'(sbq.size()), 64'd0);

    // Reset during stage 1 WAIT.
    go(cyc + 2);
    t = cyc;
    push(t + 1, 4'b0001, 1'b0);
    push(t + 7, 4'b0010, 1'b0);
    i_start = 1'b1;
    go(t + 1);
    i_start = 1'b0;
    go(t + 10);
    rst_n = 1'b0;
    go(t + 11);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    chk_at(t + 40);
    check("rst_busy_late", 64'(o_busy), 64'd0);
    check("rst_sb_empty", 64'(sbq.size()), 64'd0);

    // Back-to-back runs with start held high.
    go(cyc + 2);
    t = cyc;
    push_run(t);
    push_run(t + 26);
    i_start = 1'b1;
    chk_at(t + 26);
    check("b2b_idle_busy", 64'(o_busy), 64'd0);
    check("b2b_idle_cnt", 64'(o_cycle_count), 64'd25);
    chk_at(t + 27);
    check("b2b_busy2", 64'(o_busy), 64'd1);
    check("b2b_cnt_restart", 64'(o_cycle_count), 64'd0);
    check("b2b_idx_restart", 64'(o_stage_idx), 64'd0);
    go(t + 30);
    i_start = 1'b0;
    chk_at(t + 52);
    check("b2b_cnt2", 64'(o_cycle_count), 64'd25);
    check("b2b_idx2", 64'(o_stage_idx), 64'd3);
    chk_at(t + 53);
    check("b2b_no_third", 64'(o_busy), 64'd0);
    check("b2b_sb_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
